led_uart_reporter: RTL and testbench
====================================

# led_uart_reporter

Downstream consumer of the MiniAlu `oLed[7:0]` bus. It detects every change of the LED byte, queues the new values in a small FIFO and serialises them out as 8N1 UART frames. This gives the lab board a host-visible trace of program execution. It sits beside the LED pins at top level, sharing the MiniAlu clock and reset.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range ≥2.
- `FIFO_DEPTH`, 4: queue entries; must be a power of two ≥2.
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  reset, asynchronous and active-high.
- `iLed`  in  8  LED byte, driven by MiniAlu `oLed`.
- `oTxd`  out  1  UART serial output; idle high.
- `oBusy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `oOverflow`  out  1  sticky flag: a change was dropped because the FIFO was full.

## Operation
- Reset values:
  - `oTxd`=1, `oBusy`=0, `oOverflow`=0.
  - FIFO empty; previous-value register `rPrevLed`=0x00; TX state IDLE.
- Change detect:
  - `rPrevLed` loads `iLed` on every edge.
  - At an edge where `iLed != rPrevLed`, `iLed` is pushed into the FIFO.
  - A first nonzero value after reset is therefore reported.
  - Changes back to 0x00 are reported.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address, so full and empty are distinguishable.
  - Push while full and no pop in the same cycle: the value is dropped and `oOverflow` is set. It stays set until reset.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
  - Pop while empty never happens; TX only pops when the FIFO is non-empty.
- TX state machine (states IDLE, START, DATA, STOP):
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the bit counter and go to START. Otherwise stay.
  - START: `oTxd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `oTxd`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `oTxd` is registered; it is 1 in IDLE and STOP.
- `oBusy` = (state != IDLE) OR FIFO non-empty, decoded from registers only.

## Timing
- Change-detect latency:
  - The change is sampled at edge k and written into the FIFO at edge k.
  - IDLE pops at edge k+1.
  - `oTxd` falls at edge k+2.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles, start bit through end of stop bit.
- Back-to-back frames have exactly one IDLE cycle between the end of STOP and the next pop. The frame period is 10·`CLKS_PER_BIT`+1 cycles.
- `oBusy` rises at edge k and falls on the edge the machine returns to IDLE with the FIFO empty.
- Reset mid-frame: `oTxd` goes to 1 immediately (asynchronously). The FIFO and flags clear. No partial frame resumes after release.
- Bit-timer counter width is clog2(`CLKS_PER_BIT`). It wraps to 0 at `CLKS_PER_BIT`-1 and advances the bit.

## Structure
- Shared package `led_uart_pkg`:
  - TX state enum (IDLE=0, START=1, DATA=2, STOP=3).
  - `UART_DATA_BITS`=8.
  - Default `CLKS_PER_BIT` and `FIFO_DEPTH` constants.
- Sub-module `led_uart_tx`: the serialiser FSM, bit timer and shift register.
  - Ports: Clock, Reset, iValid, iData[7:0], oReady, oTxd.
  - The top level holds the change detector, the FIFO and `oOverflow`, and generates the pop on iValid & oReady.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4, 10 ns clock.
- Hold `Reset` for 50 ns -> `oTxd`=1, `oBusy`=0, `oOverflow`=0 throughout, and no frame while `iLed` stays 0x00 for 500 ns.
- `iLed` 0x00→0xA5 and held -> `oTxd` falls 2 cycles later and sends 0,1,0,1,0,0,1,0,1,1 (4 cycles per bit, 40 cycles total). `oBusy` then drops.
- `iLed` steps 0x01..0x06 on six consecutive cycles:
  - frames 0x01, 0x02, 0x03, 0x04, 0x05 are sent with a 41-cycle period;
  - 0x06 is dropped and `oOverflow`=1 stays set until reset.
- `iLed` 0x3C→0x00 after an idle period -> one frame 0x00 (start bit, eight 0 data bits, stop).
- Assert `Reset` during data bit 3 of a 0xFF frame with 2 entries queued:
  - `oTxd`=1 within the same cycle;
  - after release, `oBusy`=0 and no frame is emitted.
- Simultaneous push and pop with the FIFO full (pop at the IDLE cycle between frames) -> the push is accepted, `oOverflow` stays 0, and all values arrive in order.

Source files
------------

// File: rtl/led_uart_pkg.sv
// rtl/led_uart_pkg.sv - shared constants and TX state type for the LED UART reporter
package led_uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/led_uart_tx.sv
// rtl/led_uart_tx.sv - 8N1 serialiser: FSM, bit timer and shift register
module led_uart_tx
    import led_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iValid,
    input  logic [UART_DATA_BITS-1:0] iData,
    output logic                      oReady,
    output logic                      oTxd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [CW-1:0]             clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      bit_done;

    assign bit_done = (clk_cnt_q == CNT_MAX);
    assign oReady   = (state_q == TX_IDLE);
    assign oTxd     = txd_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        txd_d     = 1'b1;
        case (state_q)
            TX_IDLE: begin
                clk_cnt_d = '0;
                if (iValid) begin
                    shift_d   = iData;
                    bit_cnt_d = '0;
                    state_d   = TX_START;
                end
            end
            default: begin
                clk_cnt_d = bit_done ? '0 : clk_cnt_q + CW'(1);
                if (bit_done) begin
                    case (state_q)
                        TX_START: state_d = TX_DATA;
                        TX_DATA: begin
                            shift_d = shift_q >> 1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_d = TX_STOP;
                            end else begin
                                bit_cnt_d = bit_cnt_q + BW'(1);
                            end
                        end
                        TX_STOP: state_d = TX_IDLE;
                        default: ;
                    endcase
                end
            end
        endcase
        // Line level follows the current state, so it lags the FSM by one cycle
        case (state_q)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= TX_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: rtl/led_uart_reporter.sv
// rtl/led_uart_reporter.sv - LED change detector, FIFO and overflow flag feeding the UART serialiser
module led_uart_reporter
    import led_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [UART_DATA_BITS-1:0] iLed,
    output logic                      oTxd,
    output logic                      oBusy,
    output logic                      oOverflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [UART_DATA_BITS-1:0] prev_led_q;
    logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]               wr_ptr_q, rd_ptr_q;
    logic                      overflow_q;
    logic                      empty, full, push, pop, push_ok, tx_ready;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push    = (iLed != prev_led_q);
    assign pop     = !empty && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the push
    assign push_ok = push && (!full || pop);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prev_led_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_led_q <= iLed;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= iLed;
        end
    end

    led_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .Clock (Clock),
        .Reset (Reset),
        .iValid(!empty),
        .iData (mem_q[rd_ptr_q[AW-1:0]]),
        .oReady(tx_ready),
        .oTxd  (oTxd)
    );

    assign oBusy     = !tx_ready || !empty;
    assign oOverflow = overflow_q;

endmodule

// File: tb/tb_led_uart_reporter.sv
// tb/tb_led_uart_reporter.sv - scoreboard bench for led_uart_reporter
module tb_led_uart_reporter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iLed  = 8'h00;
    logic       oTxd, oBusy, oOverflow;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         starts_q[$];
    int         last_start = -1;
    bit         mon_en = 1'b0;
    bit         in_frame = 1'b0;

    led_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iLed     (iLed),
        .oTxd     (oTxd),
        .oBusy    (oBusy),
        .oOverflow(oOverflow)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v, output int k);
        @(negedge Clock);
        iLed = v;
        k = cyc + 1;
    endtask

    task automatic drive_at(input int e, input logic [7:0] v);
        do @(negedge Clock); while (cyc + 1 < e);
        iLed = v;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge Clock);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || oBusy !== 1'b0 || in_frame) && n < limit) begin
            @(negedge Clock);
            n++;
        end
        chk("drain_in_time", n < limit, 1);
        repeat (4) @(negedge Clock);
    endtask

    task automatic quiet_window(input int n, input string tag);
        int lows, busys, ovfs;
        lows = 0; busys = 0; ovfs = 0;
        repeat (n) begin
            @(negedge Clock);
            if (oTxd !== 1'b1) lows++;
            if (oBusy !== 1'b0) busys++;
            if (oOverflow !== 1'b0) ovfs++;
        end
        chk({tag, "_txd_low_cycles"}, lows, 0);
        chk({tag, "_busy_cycles"}, busys, 0);
        chk({tag, "_ovf_cycles"}, ovfs, 0);
    endtask

    // UART receiver: samples mid-bit and scores each decoded frame
    initial begin : uart_mon
        int t0;
        logic [9:0] bits;
        forever begin
            @(negedge Clock);
            if (mon_en && !Reset && oTxd === 1'b0) begin
                t0 = cyc;
                in_frame = 1'b1;
                last_start = t0;
                starts_q.push_back(t0);
                for (int b = 0; b < 10; b++) begin
                    while (cyc < t0 + b * CPB + CPB / 2) @(negedge Clock);
                    bits[b] = oTxd;
                end
                chk("start_bit", bits[0], 0);
                chk("stop_bit", bits[9], 1);
                chk("frame_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("frame_data", bits[8:1], exp_q.pop_front());
                in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;

        quiet_window(6, "reset_hold");
        Reset = 1'b0;
        mon_en = 1'b1;
        quiet_window(50, "idle_zero");

        exp_q.push_back(8'hA5);
        drive(8'hA5, k);
        wait_until(k);
        chk("a5_busy_rise", oBusy, 1);
        wait_until(k + 1);
        chk("a5_txd_high_k1", oTxd, 1);
        wait_until(k + 3);
        chk("a5_start_cycle", last_start, k + 2);
        wait_until(k + 40);
        chk("a5_busy_late", oBusy, 1);
        wait_until(k + 41);
        chk("a5_busy_fall", oBusy, 0);
        wait_idle(200);

        starts_q.delete();
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        drive(8'h01, k);
        for (int i = 1; i <= 5; i++) drive_at(k + i, 8'(i + 1));
        chk("burst_ovf_before_drop", oOverflow, 0);
        wait_until(k + 5);
        chk("burst_ovf_set", oOverflow, 1);
        wait_idle(400);
        chk("burst_frame_count", starts_q.size(), 5);
        for (int i = 0; i + 1 < starts_q.size(); i++)
            chk("burst_period", starts_q[i + 1] - starts_q[i], 41);
        chk("burst_ovf_sticky", oOverflow, 1);

        exp_q.push_back(8'h3C);
        drive(8'h3C, k);
        wait_idle(200);
        repeat (10) @(negedge Clock);
        exp_q.push_back(8'h00);
        drive(8'h00, k);
        wait_idle(200);
        chk("zero_ovf_sticky", oOverflow, 1);

        mon_en = 1'b0;
        drive(8'hFF, k);
        drive_at(k + 1, 8'h0F);
        drive_at(k + 2, 8'hF0);
        wait_until(k + 19);
        chk("rst_busy_before", oBusy, 1);
        #2 Reset = 1'b1;
        #1;
        chk("rst_txd_async", oTxd, 1);
        chk("rst_busy_async", oBusy, 0);
        chk("rst_ovf_async", oOverflow, 0);
        iLed = 8'h00;
        quiet_window(3, "rst_mid");
        Reset = 1'b0;
        mon_en = 1'b1;
        quiet_window(100, "post_rst");

        for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i * 8'h11));
        drive(8'h11, k);
        for (int i = 2; i <= 5; i++) drive_at(k + i, 8'(i * 8'h11));
        drive_at(k + 42, 8'h66);
        wait_until(k + 43);
        chk("full_pushpop_ovf", oOverflow, 0);
        wait_idle(600);
        chk("full_pushpop_ovf_end", oOverflow, 0);
        chk("full_pushpop_all_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
